// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encodings and PC constants.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit modulo-2^32 adder, no carry out.
// Latency: combinational. Backpressure: none.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mux_2x1_32bit.sv
// 32-bit two-way select: i_sel=0 picks i_d0, i_sel=1 picks i_d1.
// Latency: combinational. Backpressure: none.
module mux_2x1_32bit (
  input  logic        i_sel,
  input  logic [31:0] i_d0,
  input  logic [31:0] i_d1,
  output logic [31:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues req/ack imem reads, buffers {pc, pc+4, instr} for decode.
// Latency: one instruction per 2 cycles with 0-wait memory; redirect reaches memory 1 cycle later.
// Backpressure: a one-entry buffer holds all id_* outputs stable while id_ready_i is low.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc_plus4_o,
  output logic [XLEN-1:0] id_instr_o
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_stale_addr;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_pc_plus4;
  logic [XLEN-1:0] r_id_instr;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_pc_en;
  logic            w_buf_load;
  logic            w_buf_clear;

  adder_32bit u_pc_adder (
    .a   (r_pc),
    .b   (PC_INC),
    .sum (w_pc_plus4)
  );

  assign w_redirect_pc = redirect_pc_i & PC_ALIGN_MASK;

  mux_2x1_32bit u_next_pc_mux (
    .i_sel (redirect_i),
    .i_d0  (w_pc_plus4),
    .i_d1  (w_redirect_pc),
    .o_y   (w_next_pc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_en     = redirect_i;
    w_buf_load  = 1'b0;
    w_buf_clear = redirect_i;
    case (r_state)
      FETCH: begin
        if (redirect_i) begin
          // An outstanding request must complete before the new PC can be issued.
          w_state_nxt = imem_ack_i ? FETCH : DISCARD;
        end else if (imem_ack_i) begin
          w_state_nxt = HOLD;
          w_pc_en     = 1'b1;
          w_buf_load  = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_i || id_ready_i) begin
          w_state_nxt = FETCH;
          w_buf_clear = 1'b1;
        end
      end
      DISCARD: begin
        // The stale read is finished once acked, even if another redirect lands now.
        if (imem_ack_i) begin
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_pc_en) begin
      r_pc <= w_next_pc;
    end
  end

  // Remembers the in-flight address so it stays on the bus after a redirect moves the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stale_addr <= '0;
    end else if (r_state == FETCH) begin
      r_stale_addr <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid    <= 1'b0;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_id_instr    <= '0;
    end else begin
      if (w_buf_load) begin
        r_id_valid    <= 1'b1;
        r_id_pc       <= r_pc;
        r_id_pc_plus4 <= w_pc_plus4;
        r_id_instr    <= imem_rdata_i;
      end else if (w_buf_clear) begin
        r_id_valid    <= 1'b0;
      end
    end
  end

  assign imem_req_o    = (r_state == FETCH) || (r_state == DISCARD);
  assign imem_addr_o   = (r_state == DISCARD) ? r_stale_addr : r_pc;
  assign id_valid_o    = r_id_valid;
  assign id_pc_o       = r_id_pc;
  assign id_pc_plus4_o = r_id_pc_plus4;
  assign id_instr_o    = r_id_instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed sequences, a redirect vector table and a random run.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;
  logic [31:0] id_instr_o;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_pc_plus4_o (id_pc_plus4_o),
    .id_instr_o    (id_instr_o)
  );

  always #5 clk = ~clk;

  // Memory model: fixed wait states, or a random ack bit in the random phase.
  int lat;
  int cnt;
  bit rnd_mode;
  bit rnd_ack;
  assign imem_ack_i   = imem_req_o && (rnd_mode ? rnd_ack : (cnt >= lat));
  assign imem_rdata_i = 32'hA000_0000 | imem_addr_o;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (!imem_req_o || imem_ack_i) cnt <= 0;
    else cnt <= cnt + 1;
  end

  int n_tests;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!id_valid_o && n < 30);
    chk1("valid_within_bound", id_valid_o, 1'b1);
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    logic [31:0] exp_instr;
    logic [31:0] exp_next;
  } vec_t;
  vec_t tbl[5];

  logic [31:0] exp_pc;
  bit          p_pend;
  bit          p_hold;
  logic [31:0] p_addr;
  logic [31:0] p_pc;
  logic [31:0] p_instr;
  int          idle;
  int          max_idle;

  task automatic step_rand();
    tick();
    if (p_pend) begin
      chk1("rnd_req_held", imem_req_o, 1'b1);
      chk("rnd_addr_held", imem_addr_o, p_addr);
    end
    if (p_hold) begin
      chk1("rnd_stall_valid", id_valid_o, 1'b1);
      chk("rnd_stall_pc", id_pc_o, p_pc);
      chk("rnd_stall_instr", id_instr_o, p_instr);
    end
    if (id_valid_o) chk1("rnd_req_low_when_valid", imem_req_o, 1'b0);
    redirect_i    = ($urandom_range(0, 9) == 0);
    redirect_pc_i = $urandom();
    id_ready_i    = ($urandom_range(0, 2) != 0);
    rnd_ack       = 1'($urandom_range(0, 1));
    #1;
    if (id_valid_o && id_ready_i) begin
      chk("rnd_pc", id_pc_o, exp_pc);
      chk("rnd_pc_plus4", id_pc_plus4_o, exp_pc + 32'd4);
      chk("rnd_instr", id_instr_o, 32'hA000_0000 | exp_pc);
      exp_pc = exp_pc + 32'd4;
      idle   = 0;
    end else begin
      idle++;
      if (idle > max_idle) max_idle = idle;
    end
    if (redirect_i) exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
    p_pend  = imem_req_o && !imem_ack_i;
    p_addr  = imem_addr_o;
    p_hold  = id_valid_o && !id_ready_i && !redirect_i;
    p_pc    = id_pc_o;
    p_instr = id_instr_o;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b1;
    lat = 0; rnd_mode = 1'b0; rnd_ack = 1'b0;
    n_tests = 0; n_fail = 0;

    tbl[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'hA000_0100, 32'h0000_0104};
    tbl[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204, 32'hA000_0200, 32'h0000_0204};
    tbl[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFC, 32'h8000_0000, 32'hFFFF_FFFC, 32'h8000_0000};
    tbl[4] = '{32'h1234_5679, 32'h1234_5678, 32'h1234_567C, 32'hB234_5678, 32'h1234_567C};

    tick(); tick();
    chk1("reset_valid", id_valid_o, 1'b0);
    chk("reset_id_pc", id_pc_o, 32'h0);
    chk("reset_id_pc_plus4", id_pc_plus4_o, 32'h0);
    chk("reset_id_instr", id_instr_o, 32'h0);
    chk("reset_addr", imem_addr_o, 32'h0);
    rst = 1'b0;
    chk1("first_req", imem_req_o, 1'b1);

    // Streaming with 0-wait memory, then stall with pc=8 buffered.
    for (int k = 0; k < 3; k++) begin
      wait_valid(n);
      chk("stream_gap", n, (k == 0) ? 32'd1 : 32'd2);
      chk("stream_pc", id_pc_o, 32'(4 * k));
      chk("stream_pc_plus4", id_pc_plus4_o, 32'(4 * k + 4));
      chk("stream_instr", id_instr_o, 32'hA000_0000 | 32'(4 * k));
      if (k == 2) id_ready_i = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("stall_valid", id_valid_o, 1'b1);
      chk("stall_pc", id_pc_o, 32'h8);
      chk("stall_instr", id_instr_o, 32'hA000_0008);
      chk1("stall_req", imem_req_o, 1'b0);
    end
    id_ready_i = 1'b1;
    tick();
    chk1("release_valid", id_valid_o, 1'b0);
    chk1("release_req", imem_req_o, 1'b1);
    chk("release_addr", imem_addr_o, 32'hC);

    // Asynchronous reset in the middle of a run.
    tick();
    chk("pre_reset_pc", id_pc_o, 32'hC);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_valid", id_valid_o, 1'b0);
    chk("async_rst_addr", imem_addr_o, 32'h0);
    chk("async_rst_id_pc", id_pc_o, 32'h0);
    tick();
    rst = 1'b0;
    chk1("post_rst_req", imem_req_o, 1'b1);
    chk("post_rst_addr", imem_addr_o, 32'h0);
    wait_valid(n);
    chk("post_rst_gap", n, 32'd1);
    chk("post_rst_pc", id_pc_o, 32'h0);

    // Redirect while a slow request is outstanding.
    lat = 3;
    tick();
    chk("wait_addr", imem_addr_o, 32'h4);
    chk1("wait_no_ack", imem_ack_i, 1'b0);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    chk1("discard_valid", id_valid_o, 1'b0);
    chk1("discard_req", imem_req_o, 1'b1);
    chk("discard_stale_addr", imem_addr_o, 32'h4);
    wait_valid(n);
    chk("redir_wait_pc", id_pc_o, 32'h100);
    chk("redir_wait_pc_plus4", id_pc_plus4_o, 32'h104);
    chk("redir_wait_instr", id_instr_o, 32'hA000_0100);

    // Redirect in the same cycle as a 0-wait ack.
    lat = 0;
    tick();
    chk("same_cycle_addr", imem_addr_o, 32'h104);
    chk1("same_cycle_ack", imem_ack_i, 1'b1);
    redirect_i = 1'b1; redirect_pc_i = 32'h203;
    tick();
    redirect_i = 1'b0;
    chk1("same_cycle_valid", id_valid_o, 1'b0);
    chk("same_cycle_next_addr", imem_addr_o, 32'h200);
    wait_valid(n);
    chk("same_cycle_pc", id_pc_o, 32'h200);
    chk("same_cycle_instr", id_instr_o, 32'hA000_0200);

    // Redirect vector table, each applied from HOLD.
    for (int v = 0; v < 5; v++) begin
      id_ready_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = tbl[v].target;
      tick();
      redirect_i = 1'b0; id_ready_i = 1'b1;
      chk1("tbl_valid_dropped", id_valid_o, 1'b0);
      chk1("tbl_req", imem_req_o, 1'b1);
      chk("tbl_addr", imem_addr_o, tbl[v].exp_pc);
      wait_valid(n);
      chk("tbl_gap", n, 32'd1);
      chk("tbl_pc", id_pc_o, tbl[v].exp_pc);
      chk("tbl_pc_plus4", id_pc_plus4_o, tbl[v].exp_p4);
      chk("tbl_instr", id_instr_o, tbl[v].exp_instr);
      tick();
      chk("tbl_next_addr", imem_addr_o, tbl[v].exp_next);
      wait_valid(n);
    end

    // Random phase against the transfer-level model.
    rst = 1'b1;
    tick();
    rst = 1'b0; rnd_mode = 1'b1;
    exp_pc = 32'h0; p_pend = 1'b0; p_hold = 1'b0; idle = 0; max_idle = 0;
    for (int i = 0; i < 3000; i++) step_rand();
    chk1("rnd_liveness", (max_idle <= 200), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
